shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that executes an N-position shift or rotate on a WIDTH-bit operand by stepping a single-position shift datapath once per clock. It sits between the CPU's instruction/execute control and the shifter datapath. It uses a start/ready handshake toward control and returns the result with a one-cycle completion strobe and a carry flag.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- AMTW, $clog2(WIDTH), width of the shift-amount field (amount range 0..WIDTH-1).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low; clears all state.
- start_valid  in  1  request present.
- start_ready  out  1  sequencer can accept a request; high only in IDLE.
- cmd  in  cmd_t (3)  operation: NONE, SHL, SHR, ROL, ROR.
- amt  in  AMTW  number of single-position steps.
- din  in  WIDTH  operand.
- busy  out  1  high in SHIFT and DONE.
- result  out  WIDTH  shifted value; holds until the next accept.
- carry  out  1  last bit shifted or rotated out of the operand.
- result_valid  out  1  one-cycle completion strobe.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready, latch cmd, amt into counter, din into the working register, and clear carry.
  - Go to DONE if cmd==NONE or amt==0; otherwise go to SHIFT.
- SHIFT: each cycle:
  - working register ← one-position step per latched cmd.
  - carry ← bit leaving the register: SHL → reg[WIDTH-1]; SHR → reg[0]; ROL → reg[WIDTH-1], which also enters bit 0; ROR → reg[0], which also enters bit WIDTH-1.
  - Counter decrements; when the counter equals 1 on this step, go to DONE.
  - SHL/SHR fill with 0; SHR is logical.
- DONE: result_valid=1 for exactly this cycle, then go to IDLE unconditionally.
- result is the working register itself.
- Encodings 5–7 of cmd are treated as NONE.
- Inputs are sampled only at the accepting edge. Changes to cmd, amt or din while busy have no effect. start_valid while busy is ignored and is not queued.

## Timing
- The accepting edge is edge 0. The shift steps occur on edges 1..amt.
- result_valid is high in the cycle following edge amt. For amt==0 or NONE, that is the cycle after the accepting edge.
- Earliest next accept is the edge ending the cycle after DONE, i.e. edge amt+2.
- Throughput is therefore one request per amt+2 cycles.
- Reset values (immediately on rst_n low, independent of clk):
  - state=IDLE, start_ready=1, busy=0, result=0, carry=0, result_valid=0, counter=0.
- Reset mid-operation abandons the operation. No result_valid is produced for it.
- Counter width is AMTW; it never wraps, because SHIFT is entered only with amt≥1.

## Structure
- Package shifter_types:
  - Existing cmd_t.
  - Add seq_state_t enum {IDLE, SHIFT, DONE}, marked verilator public for bench visibility.
- Sub-module shift_step: purely combinational, parameter WIDTH.
  - Inputs: cmd_t cmd, din[WIDTH].
  - Outputs: dout[WIDTH], out_bit.
  - Implements one-position SHL/SHR/ROL/ROR; NONE passes din through with out_bit=0.
- shift_sequencer instantiates one shift_step on its working register and owns the FSM, counter and carry registers.

## Test plan
All scenarios use WIDTH=8.
- SHL, din=8'h96, amt=3:
  - result=8'hB0, carry=0.
  - result_valid only in the cycle after edge 3; busy high across edges 1–3.
- ROR, din=8'h81, amt=1 → result=8'hC0, carry=1, result_valid in the cycle after edge 1.
- ROL, din=8'hA5, amt=7 → result=8'hD2, carry=0. Then SHR, din=8'h80, amt=7 → result=8'h01, carry=0.
- SHR, din=8'hFF, amt=0 → result=8'hFF, carry=0, result_valid in the cycle after accept. cmd=NONE with amt=5 behaves identically.
- SHL, din=8'hFF, amt=7; pull rst_n low after 2 steps:
  - All outputs go to their reset values asynchronously; start_ready=1; no result_valid.
  - A following ROR, din=8'h01, amt=1 completes with result=8'h80, carry=1.
- Handshake:
  - Hold start_valid high continuously with changing din/cmd during SHIFT. The result reflects only the accepted request, and start_ready stays low until IDLE.
  - Back-to-back requests are accepted at edges 0 and amt+2.

Source files
------------

// File: rtl/shifter_types.sv
// Shared types for the shifter datapath and its multi-cycle sequencer.
package shifter_types;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      SHL  = 3'd1,
      SHR  = 3'd2,
      ROL  = 3'd3,
      ROR  = 3'd4
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   // Unused encodings 5..7 collapse to NONE so the rest of the design sees only legal commands.
   function automatic cmd_t norm_cmd(input cmd_t c);
      case (c)
         SHL, SHR, ROL, ROR: norm_cmd = c;
         default:            norm_cmd = NONE;
      endcase
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of a WIDTH-bit word; out_bit is the bit pushed out.
module shift_step
   import shifter_types::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  cmd_t             cmd,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             out_bit
);

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      dout    = din;
      out_bit = 1'b0;
      case (cmd)
         SHL: begin
            dout    = {din[WIDTH-2:0], 1'b0};
            out_bit = din[WIDTH-1];
         end
         SHR: begin
            dout    = {1'b0, din[WIDTH-1:1]};
            out_bit = din[0];
         end
         ROL: begin
            dout    = {din[WIDTH-2:0], din[WIDTH-1]};
            out_bit = din[WIDTH-1];
         end
         ROR: begin
            dout    = {din[0], din[WIDTH-1:1]};
            out_bit = din[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Executes an N-position shift/rotate by stepping shift_step once per clock.
module shift_sequencer
   import shifter_types::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  cmd_t             cmd,
   input  logic [AMTW-1:0]  amt,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             result_valid
);

   seq_state_t       state, state_n;
   cmd_t             cmd_q;
   logic [AMTW-1:0]  cnt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] step_dout;
   logic             step_bit;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .cmd     (cmd_q),
      .din     (work),
      .dout    (step_dout),
      .out_bit (step_bit)
   );

   assign accept = start_valid && (state == IDLE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_valid)
                     state_n = (norm_cmd(cmd) == NONE || amt == '0) ? DONE : SHIFT;
         SHIFT:   if (cnt == AMTW'(1)) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cmd_q <= NONE;
         cnt   <= '0;
         work  <= '0;
         carry <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            cmd_q <= norm_cmd(cmd);
            cnt   <= amt;
            work  <= din;
            carry <= 1'b0;
         end else if (state == SHIFT) begin
            work  <= step_dout;
            carry <= step_bit;
            cnt   <= cnt - AMTW'(1);
         end
      end
   end

   assign start_ready  = (state == IDLE);
   assign busy         = (state == SHIFT) || (state == DONE);
   assign result_valid = (state == DONE);
   assign result       = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer against an arithmetic shift/rotate model.
module tb_shift_sequencer;
   import shifter_types::*;

   localparam int WIDTH = 8;
   localparam int AMTW  = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   cmd_t             cmd = NONE;
   logic [AMTW-1:0]  amt = '0;
   logic [WIDTH-1:0] din = '0;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             result_valid;

   int errors = 0;
   int checks = 0;

   shift_sequencer #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .cmd          (cmd),
      .amt          (amt),
      .din          (din),
      .busy         (busy),
      .result       (result),
      .carry        (carry),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: the whole N-position operation in one arithmetic step.
   function automatic void model(input int c, input int a, input logic [7:0] d,
                                 output logic [7:0] res, output logic cy, output int steps);
      logic [15:0] w;
      w = {8'h00, d};
      res = d; cy = 1'b0; steps = 0;
      if (c < 1 || c > 4 || a == 0) return;
      steps = a;
      case (c)
         1: begin res = 8'(w << a); cy = d[8 - a]; end
         2: begin res = 8'(w >> a); cy = d[a - 1]; end
         3: begin res = 8'((w << a) | (w >> (8 - a))); cy = res[0]; end
         default: begin res = 8'((w >> a) | (w << (8 - a))); cy = res[7]; end
      endcase
   endfunction

   // Called at a negedge while idle; returns at the negedge after the cycle following DONE,
   // so a directly following call is accepted at edge amt+2.
   task automatic run_op(input int c, input int a, input logic [7:0] d, input bit noisy);
      logic [7:0] exp_res;
      logic       exp_cy;
      int         k;
      model(c, a, d, exp_res, exp_cy, k);
      check("ready_before_accept", start_ready, 1);
      start_valid = 1'b1;
      cmd = cmd_t'(3'(c));
      amt = AMTW'(a);
      din = d;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i <= k; i++) begin
         check("busy", busy, 1);
         check("ready_low_busy", start_ready, 0);
         if (i < k) begin
            check("no_early_valid", result_valid, 0);
         end else begin
            check("result_valid", result_valid, 1);
            check("result", result, exp_res);
            check("carry", carry, exp_cy);
         end
         start_valid = noisy ? 1'($urandom) : 1'b0;
         cmd = cmd_t'(3'($urandom_range(0, 7)));
         amt = AMTW'($urandom);
         din = 8'($urandom);
         @(negedge clk);
      end
      check("valid_one_cycle", result_valid, 0);
      check("ready_after", start_ready, 1);
      check("idle_not_busy", busy, 0);
      check("result_held", result, exp_res);
      start_valid = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      check("rst_valid", result_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1, 3, 8'h96, 1'b0);
      run_op(4, 1, 8'h81, 1'b0);
      run_op(3, 7, 8'hA5, 1'b0);
      run_op(2, 7, 8'h80, 1'b0);
      run_op(2, 0, 8'hFF, 1'b0);
      run_op(0, 5, 8'hFF, 1'b0);
      run_op(6, 4, 8'h3C, 1'b0);
      run_op(1, 5, 8'h5A, 1'b1);
      run_op(4, 6, 8'hC3, 1'b1);

      // Reset after two steps of a long SHL.
      start_valid = 1'b1; cmd = SHL; amt = 3'd7; din = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_busy", busy, 1);
      check("pre_rst_result", result, 8'hFC);
      rst_n = 1'b0;
      #1;
      check("arst_ready", start_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_result", result, 0);
      check("arst_carry", carry, 0);
      check("arst_valid", result_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_valid", result_valid, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_valid", result_valid, 0);
      run_op(4, 1, 8'h01, 1'b0);

      for (int n = 0; n < 40; n++)
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
